// File: rtl/led_pwm_ctrl.sv
// Per-LED brightness register file with glitch-free PWM drive and registered readback.
// Build option: define LED_FADE_EN to ramp the active duty one step per PWM period.

`ifndef LED_ADDR_WIDTH
`define LED_ADDR_WIDTH 3
`endif
`ifndef BRIGHTNESS_WIDTH
`define BRIGHTNESS_WIDTH 7
`endif

module led_pwm_ctrl #(
  parameter int NUM_LEDS   = 4,
  parameter int ADDR_WIDTH = `LED_ADDR_WIDTH,
  parameter int BR_WIDTH   = `BRIGHTNESS_WIDTH,
  parameter int PRESCALE   = 125
) (
  input  logic                  sysclk,
  input  logic                  rst_n,
  input  logic                  i_wr_valid,
  input  logic [ADDR_WIDTH-1:0] i_led_addr,
  input  logic [BR_WIDTH-1:0]   i_led_br_lvl,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  output logic [BR_WIDTH-1:0]   o_rd_br_lvl,
  output logic                  o_wr_err,
  output logic [NUM_LEDS-1:0]   o_led
);

  localparam int                PS_W     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0]   PS_LAST  = PS_W'(PRESCALE - 1);
  localparam logic [BR_WIDTH-1:0] FULL     = BR_WIDTH'(100);
  localparam logic [BR_WIDTH-1:0] CNT_LAST = BR_WIDTH'(99);

  logic [PS_W-1:0]     ps_cnt;
  logic                tick;
  logic                pb;
  logic [BR_WIDTH-1:0] cnt;
  logic [BR_WIDTH-1:0] target [NUM_LEDS];
  logic [BR_WIDTH-1:0] active [NUM_LEDS];
  logic [NUM_LEDS-1:0] wr_sel;
  logic                wr_hit;
  logic [BR_WIDTH-1:0] wr_lvl;
  logic [BR_WIDTH-1:0] rd_lvl;

  // With PRESCALE=1 the counter never leaves 0, so tick is permanently high.
  assign tick   = (ps_cnt == PS_LAST);
  assign pb     = tick && (cnt == CNT_LAST);
  assign wr_hit = |wr_sel;

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      ps_cnt <= '0;
      cnt    <= '0;
    end else begin
      ps_cnt <= tick ? '0 : ps_cnt + 1'b1;
      if (tick) begin
        cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
      end
    end
  end

  // Address decode by comparison keeps out-of-range indices from ever touching the arrays.
  always_comb begin
    wr_sel = '0;
    rd_lvl = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      wr_sel[i] = i_wr_valid && (i_led_addr == ADDR_WIDTH'(i));
      if (i_rd_addr == ADDR_WIDTH'(i)) begin
        rd_lvl = target[i];
      end
    end
    wr_lvl = (i_led_br_lvl > FULL) ? FULL : i_led_br_lvl;
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_LEDS; i++) begin
        target[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_LEDS; i++) begin
        if (wr_sel[i]) begin
          target[i] <= wr_lvl;
        end
      end
    end
  end

  // Active duty only moves on the period boundary, so a period is never cut short or stretched.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_LEDS; i++) begin
        active[i] <= '0;
      end
    end else if (pb) begin
      for (int i = 0; i < NUM_LEDS; i++) begin
`ifdef LED_FADE_EN
        if (active[i] < target[i]) begin
          active[i] <= active[i] + 1'b1;
        end else if (active[i] > target[i]) begin
          active[i] <= active[i] - 1'b1;
        end
`else
        active[i] <= target[i];
`endif
      end
    end
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      o_led       <= '0;
      o_rd_br_lvl <= '0;
      o_wr_err    <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_LEDS; i++) begin
        o_led[i] <= (cnt < active[i]);
      end
      o_rd_br_lvl <= rd_lvl;
      o_wr_err    <= i_wr_valid && !wr_hit;
    end
  end

endmodule

// File: tb/tb_led_pwm_ctrl.sv
// Scoreboard bench for led_pwm_ctrl: a cycle-indexed reference model queues expected outputs,
// scenario tasks pop and compare them, plus duty-count and hazard checks. Covers LED_FADE_EN too.

module tb_led_pwm_ctrl;

  localparam int NL  = 4;
  localparam int AW  = 3;
  localparam int BW  = 7;
  localparam int PS  = 2;
  localparam int PER = 100 * PS;

  typedef struct packed {
    logic [NL-1:0] led;
    logic [BW-1:0] rd;
    logic          err;
  } exp_t;

  logic          sysclk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_wr_valid = 1'b0;
  logic [AW-1:0] i_led_addr = '0;
  logic [BW-1:0] i_led_br_lvl = '0;
  logic [AW-1:0] i_rd_addr = '0;
  logic [BW-1:0] o_rd_br_lvl;
  logic          o_wr_err;
  logic [NL-1:0] o_led;

  int   passed = 0;
  int   total = 0;
  int   cyc = 0;
  int   m_tgt [NL];
  int   m_act [NL];
  exp_t expq [$];

  led_pwm_ctrl #(
    .NUM_LEDS(NL), .ADDR_WIDTH(AW), .BR_WIDTH(BW), .PRESCALE(PS)
  ) dut (
    .sysclk(sysclk), .rst_n(rst_n), .i_wr_valid(i_wr_valid), .i_led_addr(i_led_addr),
    .i_led_br_lvl(i_led_br_lvl), .i_rd_addr(i_rd_addr), .o_rd_br_lvl(o_rd_br_lvl),
    .o_wr_err(o_wr_err), .o_led(o_led)
  );

  always #4 sysclk = ~sysclk;

  // cyc edges have elapsed since release, so the counter value seen by this edge is (cyc/PS)%100.
  function automatic exp_t predict();
    exp_t e;
    int   cnt_prev;
    e = '0;
    cnt_prev = (cyc / PS) % 100;
    for (int i = 0; i < NL; i++) begin
      e.led[i] = (cnt_prev < m_act[i]);
      if (int'(i_rd_addr) == i) e.rd = BW'(m_tgt[i]);
    end
    e.err = i_wr_valid && (int'(i_led_addr) >= NL);
    return e;
  endfunction

  always @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      cyc <= 0;
      expq.delete();
      for (int i = 0; i < NL; i++) begin
        m_tgt[i] <= 0;
        m_act[i] <= 0;
      end
    end else begin
      expq.push_back(predict());
      cyc <= cyc + 1;
      for (int i = 0; i < NL; i++) begin
        if ((cyc + 1) % PER == 0) begin
`ifdef LED_FADE_EN
          if (m_act[i] < m_tgt[i]) m_act[i] <= m_act[i] + 1;
          else if (m_act[i] > m_tgt[i]) m_act[i] <= m_act[i] - 1;
`else
          m_act[i] <= m_tgt[i];
`endif
        end
        if (i_wr_valid && int'(i_led_addr) == i)
          m_tgt[i] <= (i_led_br_lvl > 7'd100) ? 100 : int'(i_led_br_lvl);
      end
    end
  end

  task automatic next_expect(output exp_t e);
    @(negedge sysclk);
    if (expq.size() == 0) begin
      total++;
      $display("[TB] FAIL sb_empty cyc=%0d got=no entry required=1 entry", cyc);
      e = '0;
    end else begin
      e = expq.pop_front();
    end
  endtask

  task automatic test_reset();
    exp_t e;
    rst_n = 1'b0;
    repeat (3) @(negedge sysclk);
    total++; if (o_led !== '0) $display("[TB] FAIL reset_led got=%b required=0", o_led); else passed++;
    total++; if (o_rd_br_lvl !== '0) $display("[TB] FAIL reset_rd got=%0d required=0", o_rd_br_lvl); else passed++;
    total++; if (o_wr_err !== 1'b0) $display("[TB] FAIL reset_err got=%b required=0", o_wr_err); else passed++;
    rst_n = 1'b1;
    for (int c = 0; c < 2 * PS + 2; c++) begin
      next_expect(e);
      total++; if (o_led !== e.led) $display("[TB] FAIL sb_led cyc=%0d got=%b required=%b", cyc, o_led, e.led); else passed++;
      total++; if (o_rd_br_lvl !== e.rd) $display("[TB] FAIL sb_rd cyc=%0d got=%0d required=%0d", cyc, o_rd_br_lvl, e.rd); else passed++;
      total++; if (o_wr_err !== e.err) $display("[TB] FAIL sb_err cyc=%0d got=%b required=%b", cyc, o_wr_err, e.err); else passed++;
    end
  endtask

  task automatic test_duty();
    exp_t e;
    int   hi = 0;
    int   other = 0;
    i_rd_addr = 3'd1;
    i_wr_valid = 1'b1; i_led_addr = 3'd1; i_led_br_lvl = 7'd25;
    for (int c = 0; c < PER + 1; c++) begin
      next_expect(e);
      i_wr_valid = 1'b0;
      total++; if (o_led !== e.led) $display("[TB] FAIL sb_led cyc=%0d got=%b required=%b", cyc, o_led, e.led); else passed++;
      total++; if (o_rd_br_lvl !== e.rd) $display("[TB] FAIL sb_rd cyc=%0d got=%0d required=%0d", cyc, o_rd_br_lvl, e.rd); else passed++;
      total++; if (o_wr_err !== e.err) $display("[TB] FAIL sb_err cyc=%0d got=%b required=%b", cyc, o_wr_err, e.err); else passed++;
      if (c > 0 && cyc % PER == 0) break;
    end
    for (int c = 0; c < PER; c++) begin
      next_expect(e);
      total++; if (o_led !== e.led) $display("[TB] FAIL sb_led cyc=%0d got=%b required=%b", cyc, o_led, e.led); else passed++;
      if (o_led[1]) hi++;
      if (o_led[0] | o_led[2] | o_led[3]) other++;
    end
    total++; if (hi !== 50) $display("[TB] FAIL duty25_high got=%0d required=50", hi); else passed++;
    total++; if (other !== 0) $display("[TB] FAIL duty25_others got=%0d required=0", other); else passed++;
    total++; if (o_rd_br_lvl !== 7'd25) $display("[TB] FAIL duty25_rd got=%0d required=25", o_rd_br_lvl); else passed++;
  endtask

  task automatic test_full_clamp();
    exp_t e;
    int   both = 0;
    i_rd_addr = 3'd3;
    i_wr_valid = 1'b1; i_led_addr = 3'd0; i_led_br_lvl = 7'd100;
    next_expect(e);
    i_led_addr = 3'd3; i_led_br_lvl = 7'd120;
    next_expect(e);
    total++; if (o_rd_br_lvl !== e.rd) $display("[TB] FAIL sb_rd cyc=%0d got=%0d required=%0d", cyc, o_rd_br_lvl, e.rd); else passed++;
    i_wr_valid = 1'b0;
    next_expect(e);
    total++; if (o_rd_br_lvl !== 7'd100) $display("[TB] FAIL clamp_rd got=%0d required=100", o_rd_br_lvl); else passed++;
    for (int c = 0; c < PER && cyc % PER != 0; c++) begin
      next_expect(e);
      total++; if (o_led !== e.led) $display("[TB] FAIL sb_led cyc=%0d got=%b required=%b", cyc, o_led, e.led); else passed++;
      total++; if (o_wr_err !== e.err) $display("[TB] FAIL sb_err cyc=%0d got=%b required=%b", cyc, o_wr_err, e.err); else passed++;
    end
    for (int c = 0; c < PER; c++) begin
      next_expect(e);
      total++; if (o_led !== e.led) $display("[TB] FAIL sb_led cyc=%0d got=%b required=%b", cyc, o_led, e.led); else passed++;
      if (o_led[0] && o_led[3]) both++;
    end
    total++; if (both !== PER) $display("[TB] FAIL full_duty got=%0d required=%0d", both, PER); else passed++;
  endtask

  task automatic test_invalid();
    exp_t e;
    i_rd_addr = 3'd4;
    i_wr_valid = 1'b1; i_led_addr = 3'd4; i_led_br_lvl = 7'd50;
    next_expect(e);
    i_wr_valid = 1'b0;
    total++; if (o_wr_err !== 1'b1) $display("[TB] FAIL wr_err_pulse got=%b required=1", o_wr_err); else passed++;
    total++; if (o_led !== e.led) $display("[TB] FAIL sb_led cyc=%0d got=%b required=%b", cyc, o_led, e.led); else passed++;
    next_expect(e);
    total++; if (o_wr_err !== 1'b0) $display("[TB] FAIL wr_err_clear got=%b required=0", o_wr_err); else passed++;
    total++; if (o_rd_br_lvl !== 7'd0) $display("[TB] FAIL rd_out_of_range got=%0d required=0", o_rd_br_lvl); else passed++;
    i_rd_addr = 3'd1;
    i_wr_valid = 1'b1; i_led_addr = 3'd7; i_led_br_lvl = 7'd0;
    next_expect(e);
    i_wr_valid = 1'b0;
    total++; if (o_wr_err !== 1'b1) $display("[TB] FAIL wr_err_pulse7 got=%b required=1", o_wr_err); else passed++;
    next_expect(e);
    total++; if (o_rd_br_lvl !== 7'd25) $display("[TB] FAIL rd_after_invalid got=%0d required=25", o_rd_br_lvl); else passed++;
    total++; if (o_rd_br_lvl !== e.rd) $display("[TB] FAIL sb_rd cyc=%0d got=%0d required=%0d", cyc, o_rd_br_lvl, e.rd); else passed++;
    total++; if (o_wr_err !== e.err) $display("[TB] FAIL sb_err cyc=%0d got=%b required=%b", cyc, o_wr_err, e.err); else passed++;
  endtask

  task automatic test_hazard();
    exp_t e;
    int   hold = 0;
    int   hi = 0;
    i_rd_addr = 3'd2;
    for (int c = 0; c < PER && (cyc + 1) % PER != 0; c++) begin
      next_expect(e);
      total++; if (o_led !== e.led) $display("[TB] FAIL sb_led cyc=%0d got=%b required=%b", cyc, o_led, e.led); else passed++;
    end
    i_wr_valid = 1'b1; i_led_addr = 3'd2; i_led_br_lvl = 7'd60;
    next_expect(e);
    i_wr_valid = 1'b0;
    total++; if (o_rd_br_lvl !== 7'd0) $display("[TB] FAIL hazard_rd_old got=%0d required=0", o_rd_br_lvl); else passed++;
    next_expect(e);
    total++; if (o_rd_br_lvl !== 7'd60) $display("[TB] FAIL hazard_rd_new got=%0d required=60", o_rd_br_lvl); else passed++;
    for (int c = 0; c < PER && cyc % PER != 0; c++) begin
      next_expect(e);
      total++; if (o_led !== e.led) $display("[TB] FAIL sb_led cyc=%0d got=%b required=%b", cyc, o_led, e.led); else passed++;
      if (o_led[2]) hold++;
    end
    total++; if (hold !== 0) $display("[TB] FAIL hazard_hold got=%0d required=0", hold); else passed++;
    for (int c = 0; c < PER; c++) begin
      next_expect(e);
      total++; if (o_led !== e.led) $display("[TB] FAIL sb_led cyc=%0d got=%b required=%b", cyc, o_led, e.led); else passed++;
      if (o_led[2]) hi++;
    end
    total++; if (hi !== 120) $display("[TB] FAIL duty60_high got=%0d required=120", hi); else passed++;
  endtask

  task automatic test_async_reset();
    exp_t e;
    i_wr_valid = 1'b1; i_led_addr = 3'd1; i_led_br_lvl = 7'd100;
    next_expect(e);
    i_led_addr = 3'd2;
    next_expect(e);
    i_wr_valid = 1'b0;
    for (int c = 0; c < PER + 5; c++) begin
      next_expect(e);
      total++; if (o_led !== e.led) $display("[TB] FAIL sb_led cyc=%0d got=%b required=%b", cyc, o_led, e.led); else passed++;
      if (cyc % PER == 5) break;
    end
    total++; if (o_led !== 4'b1111) $display("[TB] FAIL all_on got=%b required=1111", o_led); else passed++;
    #2 rst_n = 1'b0;
    #1;
    total++; if (o_led !== '0) $display("[TB] FAIL async_led got=%b required=0", o_led); else passed++;
    total++; if (o_rd_br_lvl !== '0) $display("[TB] FAIL async_rd got=%0d required=0", o_rd_br_lvl); else passed++;
    repeat (2) @(negedge sysclk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      next_expect(e);
      total++; if (o_led !== e.led) $display("[TB] FAIL sb_led cyc=%0d got=%b required=%b", cyc, o_led, e.led); else passed++;
      total++; if (o_rd_br_lvl !== e.rd) $display("[TB] FAIL sb_rd cyc=%0d got=%0d required=%0d", cyc, o_rd_br_lvl, e.rd); else passed++;
    end
    total++; if (o_rd_br_lvl !== 7'd0) $display("[TB] FAIL rd_after_reset got=%0d required=0", o_rd_br_lvl); else passed++;
  endtask

`ifdef LED_FADE_EN
  task automatic test_fade();
    exp_t e;
    int   hi;
    int   fexp [6] = '{2, 4, 6, 8, 6, 4};
    i_rd_addr = 3'd0;
    i_wr_valid = 1'b1; i_led_addr = 3'd0; i_led_br_lvl = 7'd5;
    next_expect(e);
    i_wr_valid = 1'b0;
    for (int p = 0; p < 6; p++) begin
      for (int c = 0; c < PER && cyc % PER != 0; c++) begin
        next_expect(e);
        total++; if (o_led !== e.led) $display("[TB] FAIL sb_led cyc=%0d got=%b required=%b", cyc, o_led, e.led); else passed++;
      end
      hi = 0;
      for (int c = 0; c < PER; c++) begin
        i_wr_valid = (p == 3 && c == PER / 2);
        i_led_br_lvl = 7'd2;
        next_expect(e);
        total++; if (o_led !== e.led) $display("[TB] FAIL sb_led cyc=%0d got=%b required=%b", cyc, o_led, e.led); else passed++;
        total++; if (o_rd_br_lvl !== e.rd) $display("[TB] FAIL sb_rd cyc=%0d got=%0d required=%0d", cyc, o_rd_br_lvl, e.rd); else passed++;
        if (o_led[0]) hi++;
      end
      i_wr_valid = 1'b0;
      total++; if (hi !== fexp[p]) $display("[TB] FAIL fade_step%0d got=%0d required=%0d", p, hi, fexp[p]); else passed++;
      if (p == 1) begin
        total++; if (o_rd_br_lvl !== 7'd5) $display("[TB] FAIL fade_rd got=%0d required=5", o_rd_br_lvl); else passed++;
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_duty();
    test_full_clamp();
    test_invalid();
    test_hazard();
    test_async_reset();
`ifdef LED_FADE_EN
    test_fade();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog got=time limit required=finish passed=%0d total=%0d", passed, total);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/led_pwm_ctrl.md
Name: led_pwm_ctrl

Overview:
- Downstream consumer of the SPI slave's decoded LED commands: holds a per-LED brightness register file and drives each board LED with a PWM waveform.
- Brightness is a percentage, 0..100.
- Provides a registered readback port, used by the SPI slave to answer brightness-query commands.
- Runs entirely in the 125 MHz sysclk domain.
- SPI-side signals arrive already synchronised to sysclk.

Parameters:
- NUM_LEDS, 4, number of LEDs driven (Zybo Z7-20 user LEDs).
- ADDR_WIDTH, `LED_ADDR_WIDTH, width of LED address.
- BR_WIDTH, `BRIGHTNESS_WIDTH (7), width of brightness value in percent.
- PRESCALE, 125, sysclk cycles per PWM tick. Default gives a 1 MHz tick and a 10 kHz PWM frequency. Legal range >= 1.

Ports:
- sysclk  in  1  system clock, 125 MHz.
- rst_n  in  1  asynchronous active-low reset.
- i_wr_valid  in  1  single-cycle write strobe from the SPI slave.
- i_led_addr  in  ADDR_WIDTH  target LED index for the write.
- i_led_br_lvl  in  BR_WIDTH  requested brightness in percent.
- i_rd_addr  in  ADDR_WIDTH  readback LED index.
- o_rd_br_lvl  out  BR_WIDTH  target brightness of LED i_rd_addr. Registered, 1-cycle latency.
- o_wr_err  out  1  one-cycle pulse when a write is rejected.
- o_led  out  NUM_LEDS  PWM outputs, registered, active-high.

Behaviour:
- Clock and reset: one clock (sysclk); reset is asynchronous, active-low (rst_n). Reset clears every register immediately, with no wait for a sysclk edge.
- Reset values: o_led=0, o_rd_br_lvl=0, o_wr_err=0. Prescaler, period counter, target[] and active[] all reset to 0.
- Prescaler: counts 0..PRESCALE-1. tick=1 for one sysclk when the count equals PRESCALE-1, then the count wraps to 0. With PRESCALE=1, tick is constant 1.
- Period counter: cnt counts 0..99 and advances only on tick. It wraps 99->0. The wrap tick is the period boundary (pb).
- Write path: on a sysclk edge with i_wr_valid=1:
  - If i_led_addr < NUM_LEDS: target[addr] <= min(i_led_br_lvl, 100). Values 101..127 clamp to 100.
  - If i_led_addr >= NUM_LEDS: no state change, and o_wr_err=1 on the next cycle only.
- Write pacing: back-to-back writes on consecutive cycles are all accepted.
- Glitch-free update: active[i] is the duty actually driven. It changes only on pb, never mid-period.
- Without the fade feature: on pb, active[i] <= target[i] for all i.
- Write coinciding with pb: the new target is NOT visible at that pb. It loads at the following pb.
- PWM compare: o_led[i] <= (cnt < active[i]), registered one sysclk after cnt changes. Consequences:
  - active=0 gives a constant low output.
  - active=100 gives a constant high output.
  - active=N gives N high ticks per 100-tick period, starting at cnt=0.
- Readback: o_rd_br_lvl <= target[i_rd_addr] every cycle; it returns target, not active.
- Readback out of range: i_rd_addr >= NUM_LEDS returns 0.
- Readback hazard: a write and a read to the same address in the same cycle return the OLD value; the new value appears one cycle later.
- Reset mid-period: outputs go low immediately; counting restarts at cnt=0 after release.

Optional Feature:
- Macro: LED_FADE_EN.
- Defined: on each pb, every active[i] moves one step toward target[i]:
  - +1 if active < target;
  - -1 if active > target;
  - hold if equal.
- Fade timing: a 0->100 change takes 100 periods (10 ms at default settings).
- Fade retargeting: a new write mid-fade re-targets the ramp from the current active value, with no jump.
- Readback during a fade still returns target.
- Undefined: active[i] loads target[i] directly on pb. No fade logic is synthesised.

Test Plan:
- Reset: assert rst_n=0 mid-period with o_led=4'b1111 -> o_led=0 asynchronously. After release, o_rd_br_lvl=0 and the first tick arrives PRESCALE cycles later.
- Duty accuracy (PRESCALE=2): write LED1=25 -> from the next pb on, o_led[1] is high for exactly 25 ticks (50 sysclk) per 200-sysclk period. Other LEDs stay 0.
- Full duty and clamp: write LED0=100 and LED3=120 -> both outputs constant high after the next pb. Readback of addr 3 returns 100.
- Invalid address (NUM_LEDS=3): write addr 3 value 50 -> o_wr_err pulses for exactly 1 cycle. All targets and outputs are unchanged.
- Timing hazards:
  - Write LED2=60 on the pb cycle -> the output stays at the old duty for one full period, then switches to 60.
  - Same-cycle read of addr 2 returns the old value; the next cycle returns 60.
- LED_FADE_EN: write LED0=0->5 -> active steps 1,2,3,4,5 on five successive pb. A write of 2 when active=4 ramps 3,2 with no jump.
